// File: rtl/rs_enc_lfsr.sv
// Systematic RS(K+2,K) encoder over GF(8) (x^3+x+1), generator g(x) = x^2 + 6x + 3.
// Optional macro RS_ENC_ABORT_EN adds s_abort, which discards a partially encoded codeword.

module gf8mul (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [2:0] p
);
  logic [4:0] t;

  // Carry-less product, then fold x^3 = x+1 and x^4 = x^2+x.
  assign t[0] = a[0] & b[0];
  assign t[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign t[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
  assign t[3] = (a[2] & b[1]) ^ (a[1] & b[2]);
  assign t[4] = a[2] & b[2];

  assign p[0] = t[0] ^ t[3];
  assign p[1] = t[1] ^ t[3] ^ t[4];
  assign p[2] = t[2] ^ t[4];
endmodule

module rs_enc_lfsr #(
  parameter int K = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [2:0] s_data,
`ifdef RS_ENC_ABORT_EN
  input  logic       s_abort,
`endif
  output logic       m_valid,
  input  logic       m_ready,
  output logic [2:0] m_data,
  output logic       m_last,
  output logic       m_par
);
  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // m_data/m_par/m_last are held stable while m_valid && !m_ready, and s_ready
  // never depends on s_valid.

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAR1 = 2'd1,
    ST_PAR2 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] r1_q, r1_d;
  logic [2:0] r0_q, r0_d;
  logic       m_valid_q, m_valid_d;
  logic [2:0] m_data_q, m_data_d;
  logic       m_par_q, m_par_d;
  logic       m_last_q, m_last_d;

  logic       slot_free;
  logic       s_ready_c;
  logic       abort_c;
  logic [2:0] fb;
  logic [2:0] fb_x6;
  logic [2:0] fb_x3;

  assign fb = s_data ^ r1_q;

  gf8mul u_mul6 (
    .a (fb),
    .b (3'd6),
    .p (fb_x6)
  );

  gf8mul u_mul3 (
    .a (fb),
    .b (3'd3),
    .p (fb_x3)
  );

`ifdef RS_ENC_ABORT_EN
  assign abort_c = s_abort;
`else
  assign abort_c = 1'b0;
`endif

  assign slot_free = !m_valid_q || m_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r1_d      = r1_q;
    r0_d      = r0_q;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_par_d   = m_par_q;
    m_last_d  = m_last_q;
    s_ready_c = 1'b0;

    case (state_q)
      ST_DATA: begin
        s_ready_c = slot_free && !abort_c;
        if (s_valid && s_ready_c) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_par_d   = 1'b0;
          m_last_d  = 1'b0;
          r1_d      = r0_q ^ fb_x6;
          r0_d      = fb_x3;
          if (cnt_q == 3'(K - 1)) begin
            cnt_d   = '0;
            state_d = ST_PAR1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_PAR1: begin
        if (slot_free && !abort_c) begin
          m_data_d  = r1_q;
          m_valid_d = 1'b1;
          m_par_d   = 1'b1;
          m_last_d  = 1'b0;
          r1_d      = r0_q;
          r0_d      = '0;
          state_d   = ST_PAR2;
        end
      end
      ST_PAR2: begin
        if (slot_free && !abort_c) begin
          m_data_d  = r1_q;
          m_valid_d = 1'b1;
          m_par_d   = 1'b1;
          m_last_d  = 1'b1;
          r1_d      = '0;
          state_d   = ST_DATA;
        end
      end
      default: begin
        state_d = ST_DATA;
      end
    endcase

    // Abort drops the codeword in progress but leaves any pending output beat alone.
    if (abort_c) begin
      state_d = ST_DATA;
      cnt_d   = '0;
      r1_d    = '0;
      r0_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DATA;
      cnt_q     <= '0;
      r1_q      <= '0;
      r0_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_par_q   <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r1_q      <= r1_d;
      r0_q      <= r0_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_par_q   <= m_par_d;
      m_last_q  <= m_last_d;
    end
  end

  // s_ready is combinational, so it is masked to read low while reset is held.
  assign s_ready = s_ready_c && rst_n;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_par   = m_par_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Directed bench for rs_enc_lfsr (K=5) with a syndrome-based parity model and beat scoreboard.
// Build with RS_ENC_ABORT_EN defined to also exercise s_abort.

module tb_rs_enc_lfsr;
  localparam int K = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [2:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] m_data;
  logic       m_last;
  logic       m_par;
`ifdef RS_ENC_ABORT_EN
  logic       s_abort;
`endif

  int         n_tests = 0;
  int         n_fail = 0;
  int         srdy_low = 0;
  logic [4:0] exp_q[$];
  logic       hold_pend = 1'b0;
  logic [4:0] hold_val = '0;

  always #5 clk = ~clk;

  rs_enc_lfsr #(.K(K)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
`ifdef RS_ENC_ABORT_EN
    .s_abort (s_abort),
`endif
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_par   (m_par)
  );

  // GF(8) arithmetic via log/antilog tables, alpha = 2.
  function automatic logic [2:0] gexp(input int e);
    case (e % 7)
      0: return 3'd1;
      1: return 3'd2;
      2: return 3'd4;
      3: return 3'd3;
      4: return 3'd6;
      5: return 3'd7;
      default: return 3'd5;
    endcase
  endfunction

  function automatic int glog(input logic [2:0] v);
    case (v)
      3'd1: return 0;
      3'd2: return 1;
      3'd4: return 2;
      3'd3: return 3;
      3'd6: return 4;
      3'd7: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return gexp(glog(a) + glog(b));
  endfunction

  // Parity {p1,p0} is the unique pair making c(alpha) = c(alpha^2) = 0.
  function automatic logic [5:0] model_par(input logic [2:0] msg[K]);
    logic [5:0] res = '0;
    for (int p = 0; p < 64; p++) begin
      logic [5:0] pp;
      logic [2:0] e1, e2, c;
      pp = 6'(p);
      e1 = '0;
      e2 = '0;
      for (int i = 0; i < K + 2; i++) begin
        if (i < K) c = msg[i];
        else if (i == K) c = pp[5:3];
        else c = pp[2:0];
        e1 = gmul(e1, 3'd2) ^ c;
        e2 = gmul(e2, 3'd4) ^ c;
      end
      if (e1 == 3'd0 && e2 == 3'd0) res = pp;
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, then cross the rising edge.
  task automatic step(input logic sv, input logic [2:0] sd, input logic mr, output logic acc);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    acc = sv && s_ready;
    if (!s_ready) srdy_low++;
    if (hold_pend)
      chk("stall_hold", 8'({m_valid, m_last, m_par, m_data}), 8'({1'b1, hold_val}));
    if (m_valid && m_ready) begin
      chk("beat_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0)
        chk("beat", 8'({m_last, m_par, m_data}), 8'(exp_q.pop_front()));
    end
    hold_pend = m_valid && !m_ready;
    hold_val  = {m_last, m_par, m_data};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_cw(input logic [2:0] msg[K], input logic [2:0] p1, input logic [2:0] p0);
    for (int i = 0; i < K; i++) exp_q.push_back({2'b00, msg[i]});
    exp_q.push_back({2'b01, p1});
    exp_q.push_back({2'b11, p0});
  endtask

  task automatic send(input logic [2:0] msg[K], input int vp, input int rp);
    int   idx = 0;
    int   cyc = 0;
    logic acc, sv, mr;
    while (idx < K && cyc < 400) begin
      sv = ($urandom_range(99) < vp);
      mr = ($urandom_range(99) < rp);
      step(sv, msg[idx], mr, acc);
      if (acc) idx++;
      cyc++;
    end
    chk("send_done", 8'(idx), 8'(K));
  endtask

  task automatic drain();
    int   cyc = 0;
    logic acc;
    while (exp_q.size() != 0 && cyc < 200) begin
      step(1'b0, 3'd0, 1'b1, acc);
      cyc++;
    end
    chk("drain_empty", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    logic [2:0] msg[K];
    logic [5:0] par;
    logic       acc;
    int         cyc;
    int         idx;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
`ifdef RS_ENC_ABORT_EN
    s_abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 8'(m_valid), 8'd0);
    chk("rst_m_data", 8'(m_data), 8'd0);
    chk("rst_m_par", 8'(m_par), 8'd0);
    chk("rst_m_last", 8'(m_last), 8'd0);
    chk("rst_s_ready", 8'(s_ready), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero message: all-zero codeword, two s_ready bubbles.
    msg = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    push_cw(msg, 3'd0, 3'd0);
    send(msg, 100, 100);
    srdy_low = 0;
    drain();
    chk("zero_bubbles", 8'(srdy_low), 8'd2);

    // Message 1,0,0,0,0 -> parity 6,2; one-cycle latency on the first beat.
    msg = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    push_cw(msg, 3'd6, 3'd2);
    step(1'b1, 3'd1, 1'b1, acc);
    chk("lat_accept", 8'(acc), 8'd1);
    chk("lat_valid", 8'(m_valid), 8'd1);
    chk("lat_data", 8'(m_data), 8'd1);
    chk("lat_par", 8'(m_par), 8'd0);
    for (int i = 1; i < K; i++) step(1'b1, 3'd0, 1'b1, acc);
    drain();

    // Two all-ones codewords back to back: parity 1,1, 12 cycles for 10 inputs.
    msg = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    push_cw(msg, 3'd1, 3'd1);
    push_cw(msg, 3'd1, 3'd1);
    srdy_low = 0;
    cyc = 0;
    idx = 0;
    while (idx < 2 * K && cyc < 40) begin
      step(1'b1, 3'd1, 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    chk("b2b_cycles", 8'(cyc), 8'd12);
    chk("b2b_bubbles", 8'(srdy_low), 8'd2);
    drain();

    // Random stalls and input gaps against the syndrome model.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < K; i++) msg[i] = 3'($urandom_range(7));
      par = model_par(msg);
      push_cw(msg, par[5:3], par[2:0]);
      send(msg, 70, 50);
    end
    drain();

    // Reset after the third symbol discards the partial codeword.
    exp_q.push_back({2'b00, 3'd5});
    exp_q.push_back({2'b00, 3'd3});
    step(1'b1, 3'd5, 1'b1, acc);
    step(1'b1, 3'd3, 1'b1, acc);
    step(1'b1, 3'd6, 1'b1, acc);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 8'(m_valid), 8'd0);
    chk("midrst_m_data", 8'(m_data), 8'd0);
    chk("midrst_s_ready", 8'(s_ready), 8'd0);
    hold_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    msg = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    push_cw(msg, 3'd6, 3'd2);
    send(msg, 100, 100);
    drain();

`ifdef RS_ENC_ABORT_EN
    // Abort after two symbols while the second beat is stalled; the held beat survives.
    exp_q.push_back({2'b00, 3'd3});
    exp_q.push_back({2'b00, 3'd5});
    step(1'b1, 3'd3, 1'b1, acc);
    step(1'b1, 3'd5, 1'b1, acc);
    step(1'b0, 3'd0, 1'b0, acc);
    s_abort = 1'b1;
    step(1'b1, 3'd7, 1'b0, acc);
    step(1'b1, 3'd4, 1'b1, acc);
    chk("abort_drop", 8'(acc), 8'd0);
    s_abort = 1'b0;
    msg = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    push_cw(msg, 3'd1, 3'd1);
    send(msg, 100, 100);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
